// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multi-cycle RV32I controller.
// Holds the FSM state type, the opcode-class values (inst[6:2]), the
// one-hot class struct, and the imm_sel / pc_sel / wb_sel encodings that
// the immediate extender and the datapath muxes also decode.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_OP     = 5'b01100;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_ALU    = 2'd1;
  localparam logic [1:0] PC_ALUOUT = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;
  localparam logic [1:0] WB_IMM    = 2'd3;

  typedef struct packed {
    logic load;
    logic opimm;
    logic jalr;
    logic store;
    logic branch;
    logic lui;
    logic auipc;
    logic jal;
    logic op;
  } op_class_t;

  function automatic logic [2:0] imm_sel_of(input op_class_t c);
    if (c.load || c.opimm || c.jalr) return IMM_I;
    if (c.store)                     return IMM_S;
    if (c.branch)                    return IMM_B;
    if (c.lui || c.auipc)            return IMM_U;
    if (c.jal)                       return IMM_J;
    return IMM_NONE;
  endfunction

  function automatic logic [1:0] wb_sel_of(input op_class_t c);
    if (c.load)           return WB_MDR;
    if (c.jal || c.jalr)  return WB_PC4;
    if (c.lui)            return WB_IMM;
    return WB_ALUOUT;
  endfunction

endpackage

// File: rtl/op_class_dec.sv
// op_class_dec: combinational opcode-class decoder.
// Ports: inst (instruction register) -> cls (one-hot class), illegal
// (no legal class, or inst[1:0] is not 2'b11). cls is all-zero when illegal.
module op_class_dec
  import ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output op_class_t   cls,
  output logic        illegal
);

  // Only the opcode field matters for sequencing.
  logic unused_inst_bits;
  assign unused_inst_bits = ^inst[31:7];

  always_comb begin
    cls = '0;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:2])
        OPC_LOAD:   cls.load   = 1'b1;
        OPC_OPIMM:  cls.opimm  = 1'b1;
        OPC_JALR:   cls.jalr   = 1'b1;
        OPC_STORE:  cls.store  = 1'b1;
        OPC_BRANCH: cls.branch = 1'b1;
        OPC_LUI:    cls.lui    = 1'b1;
        OPC_AUIPC:  cls.auipc  = 1'b1;
        OPC_JAL:    cls.jal    = 1'b1;
        OPC_OP:     cls.op     = 1'b1;
        default:    cls        = '0;
      endcase
    end
  end

  assign illegal = ~|cls;

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle control FSM for the RV32I datapath.
// Inputs : clk, rst (sync, active-high), inst, mem_ready, br_taken.
// Outputs: memory request (mem_req/mem_we), datapath strobes (ir_we, mdr_we,
//          alu_out_we, rf_we, pc_we), mux selects (pc_sel, alu_src_a,
//          alu_src_b, imm_sel, wb_sel), halted, instret.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_FETCH  | read instruction, load IR on mem_ready
// S_DECODE | one cycle for class decode; illegal traps
// S_EXEC   | ALU op, latch ALUOut; branches retire here
// S_MEM    | load/store access, held until mem_ready
// S_WB     | register write, PC update, retire
// S_HALT   | illegal instruction trapped; only rst leaves
module multi_cycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst,
  input  logic             mem_ready,
  input  logic             br_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             alu_out_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic [2:0]       imm_sel,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  state_t    state;
  op_class_t cls;
  logic      illegal;
  logic      retire;

  op_class_dec u_dec (
    .inst    (inst),
    .cls     (cls),
    .illegal (illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      if (retire) instret <= instret + CNT_W'(1);
      case (state)
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: state <= illegal ? S_HALT : S_EXEC;
        S_EXEC: begin
          if (cls.branch)                state <= S_FETCH;
          else if (cls.load || cls.store) state <= S_MEM;
          else                           state <= S_WB;
        end
        S_MEM:    if (mem_ready) state <= cls.store ? S_FETCH : S_WB;
        S_WB:     state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Outputs follow the state register; the rst gate keeps every strobe low
  // in the reset cycle itself, whatever state is being aborted.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    mdr_we     = 1'b0;
    alu_out_we = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = PC_PLUS4;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    imm_sel    = imm_sel_of(cls);
    wb_sel     = wb_sel_of(cls);
    halted     = 1'b0;
    retire     = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        S_EXEC: begin
          alu_out_we = 1'b1;
          alu_src_a  = cls.auipc | cls.jal | cls.branch;
          alu_src_b  = ~cls.op;
          if (cls.branch) begin
            pc_we  = 1'b1;
            pc_sel = br_taken ? PC_ALU : PC_PLUS4;
            retire = 1'b1;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = cls.store;
          if (mem_ready) begin
            if (cls.store) begin
              pc_we  = 1'b1;
              retire = 1'b1;
            end else begin
              mdr_we = 1'b1;
            end
          end
        end
        S_WB: begin
          rf_we  = 1'b1;
          pc_we  = 1'b1;
          retire = 1'b1;
          // JALR's bit-0 clear happens in the PC logic, not here.
          pc_sel = (cls.jal || cls.jalr) ? PC_ALUOUT : PC_PLUS4;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
module tb_multi_cycle_ctrl;

  localparam int TB_CNT_W = 4;

  typedef enum int {C_LOAD, C_OPIMM, C_JALR, C_STORE, C_BRANCH,
                    C_LUI, C_AUIPC, C_JAL, C_OP} cls_e;

  typedef struct {
    int         cycles;
    int         memreq_n;
    int         memwe_n;
    int         ir_n;
    int         alu_n;
    int         rf_n;
    int         mdr_n;
    logic [1:0] pc_sel;
    logic [1:0] wb_sel;
    logic [2:0] imm_sel;
    logic       src_a;
    logic       src_b;
    logic [TB_CNT_W-1:0] instret;
  } exp_t;

  logic clk = 1'b0;
  logic rst, mem_ready, br_taken;
  logic [31:0] inst;
  logic mem_req, mem_we, ir_we, mdr_we, alu_out_we, rf_we, pc_we;
  logic [1:0] pc_sel, wb_sel;
  logic alu_src_a, alu_src_b, halted;
  logic [2:0] imm_sel;
  logic [TB_CNT_W-1:0] instret;

  int tests = 0;
  int errors = 0;
  exp_t exp_q[$];
  logic [TB_CNT_W-1:0] model_cnt;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready),
    .br_taken(br_taken), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
    .mdr_we(mdr_we), .alu_out_we(alu_out_we), .rf_we(rf_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_sel(imm_sel), .wb_sel(wb_sel), .halted(halted), .instret(instret)
  );

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [4:0] opc(input cls_e c);
    case (c)
      C_LOAD:   return 5'b00000;
      C_OPIMM:  return 5'b00100;
      C_JALR:   return 5'b11001;
      C_STORE:  return 5'b01000;
      C_BRANCH: return 5'b11000;
      C_LUI:    return 5'b01101;
      C_AUIPC:  return 5'b00101;
      C_JAL:    return 5'b11011;
      default:  return 5'b01100;
    endcase
  endfunction

  // Reference model: what one instruction should look like end to end.
  function automatic exp_t model(input cls_e c, input int fst, input int mst,
                                 input bit br, input logic [TB_CNT_W-1:0] cnt);
    exp_t e;
    bit is_mem = (c == C_LOAD) || (c == C_STORE);
    e.ir_n     = 1;
    e.alu_n    = 1;
    e.instret  = cnt;
    e.cycles   = (c == C_BRANCH) ? 3 : (c == C_LOAD) ? 5 : 4;
    e.cycles   += fst + (is_mem ? mst : 0);
    e.memreq_n = fst + 1 + (is_mem ? mst + 1 : 0);
    e.memwe_n  = (c == C_STORE) ? mst + 1 : 0;
    e.rf_n     = (c == C_BRANCH || c == C_STORE) ? 0 : 1;
    e.mdr_n    = (c == C_LOAD) ? 1 : 0;
    e.pc_sel   = (c == C_BRANCH) ? (br ? 2'd1 : 2'd0) :
                 (c == C_JAL || c == C_JALR) ? 2'd2 : 2'd0;
    e.wb_sel   = (c == C_LOAD) ? 2'd1 : (c == C_JAL || c == C_JALR) ? 2'd2 :
                 (c == C_LUI) ? 2'd3 : 2'd0;
    case (c)
      C_LOAD, C_OPIMM, C_JALR: e.imm_sel = 3'd0;
      C_STORE:                 e.imm_sel = 3'd1;
      C_BRANCH:                e.imm_sel = 3'd2;
      C_LUI, C_AUIPC:          e.imm_sel = 3'd3;
      C_JAL:                   e.imm_sel = 3'd4;
      default:                 e.imm_sel = 3'd7;
    endcase
    e.src_a = (c == C_AUIPC || c == C_JAL || c == C_BRANCH);
    e.src_b = (c != C_OP);
    return e;
  endfunction

  // Memory responder: waits for mem_req, stalls 'stall' cycles, then accepts.
  task automatic serve(input int stall);
    int waited = 0;
    int guard = 0;
    bit done = 0;
    mem_ready = 1'b0;
    while (!done && guard < 300) begin
      if (mem_req && !rst) begin
        if (waited >= stall) begin
          mem_ready = 1'b1;
          @(negedge clk);
          mem_ready = 1'b0;
          done = 1;
        end else begin
          waited++;
          @(negedge clk);
        end
      end else begin
        @(negedge clk);
      end
      guard++;
    end
    if (!done) chk("serve_timeout_mem_req", int'(mem_req), 1);
  endtask

  task automatic run_instr(input logic [31:0] word, input cls_e c,
                           input int fst, input int mst, input bit br);
    exp_q.push_back(model(c, fst, mst, br, model_cnt));
    model_cnt = model_cnt + 1'b1;
    serve(fst);
    inst = word;
    br_taken = br;
    if (c == C_LOAD || c == C_STORE) serve(mst);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: accumulates per-instruction activity, compares at each retire.
  initial begin
    int cyc = 0, mreq = 0, mwe = 0, irn = 0, alun = 0, rfn = 0, mdrn = 0;
    logic sa = 0, sb = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        cyc = 0; mreq = 0; mwe = 0; irn = 0; alun = 0; rfn = 0; mdrn = 0;
      end else begin
        cyc++;
        if (mem_req) mreq++;
        if (mem_req && mem_we) mwe++;
        if (ir_we) irn++;
        if (alu_out_we) begin alun++; sa = alu_src_a; sb = alu_src_b; end
        if (rf_we) rfn++;
        if (mdr_we) mdrn++;
        if (pc_we) begin
          if (exp_q.size() == 0) begin
            chk("spurious_pc_we", int'(pc_we), 0);
          end else begin
            e = exp_q.pop_front();
            chk("latency_cycles", cyc, e.cycles);
            chk("mem_req_cycles", mreq, e.memreq_n);
            chk("mem_we_cycles", mwe, e.memwe_n);
            chk("ir_we_pulses", irn, e.ir_n);
            chk("alu_out_we_pulses", alun, e.alu_n);
            chk("rf_we_pulses", rfn, e.rf_n);
            chk("mdr_we_pulses", mdrn, e.mdr_n);
            chk("pc_sel_at_retire", int'(pc_sel), int'(e.pc_sel));
            chk("imm_sel_at_retire", int'(imm_sel), int'(e.imm_sel));
            chk("alu_src_a_exec", int'(sa), int'(e.src_a));
            chk("alu_src_b_exec", int'(sb), int'(e.src_b));
            chk("instret_before_retire", int'(instret), int'(e.instret));
            if (e.rf_n != 0) chk("wb_sel_at_wb", int'(wb_sel), int'(e.wb_sel));
          end
          cyc = 0; mreq = 0; mwe = 0; irn = 0; alun = 0; rfn = 0; mdrn = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    cls_e c;
    int bad;
    logic [TB_CNT_W-1:0] frozen;

    rst = 1'b1; inst = 32'h0; mem_ready = 1'b0; br_taken = 1'b0;
    model_cnt = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_mem_req", int'(mem_req), 0);
    chk("reset_strobes", int'({ir_we, mdr_we, alu_out_we, rf_we, pc_we}), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_mem_req", int'(mem_req), 1);
    chk("post_reset_instret", int'(instret), 0);
    chk("post_reset_halted", int'(halted), 0);

    run_instr(32'h00500093, C_OPIMM, 0, 0, 1'b0);
    run_instr(32'h0000A103, C_LOAD, 0, 3, 1'b0);
    run_instr(32'h00000463, C_BRANCH, 0, 0, 1'b1);
    run_instr(32'h008000EF, C_JAL, 0, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      c = cls_e'($urandom_range(0, 8));
      w = $urandom;
      w[6:0] = {opc(c), 2'b11};
      run_instr(w, c, $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
    end
    drain();

    // Illegal instruction traps into HALT.
    serve(0);
    inst = 32'hFFFFFFFF;
    @(negedge clk);
    frozen = model_cnt;
    bad = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      #1;
      if (!halted || mem_req || instret != frozen ||
          {ir_we, mdr_we, alu_out_we, rf_we, pc_we} != 5'b0) bad++;
    end
    chk("halt_bad_cycles", bad, 0);
    chk("halt_halted", int'(halted), 1);
    chk("halt_instret", int'(instret), int'(model_cnt));

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("halt_reset_mem_req", int'(mem_req), 0);
    chk("halt_reset_halted", int'(halted), 0);
    @(negedge clk);
    rst = 1'b0;
    model_cnt = '0;
    #1;
    chk("halt_exit_fetch_mem_req", int'(mem_req), 1);
    chk("halt_exit_instret", int'(instret), 0);

    // Reset during a stalled store in MEM.
    run_instr(32'h00500093, C_OPIMM, 1, 0, 1'b0);
    drain();
    serve(0);
    inst = 32'h0020A023;
    bad = 0;
    while (!(mem_req && mem_we) && bad < 50) begin
      @(negedge clk);
      bad++;
    end
    chk("store_mem_phase_seen", int'(mem_req && mem_we), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midop_reset_mem_req", int'(mem_req), 0);
    chk("midop_reset_pc_we", int'(pc_we), 0);
    @(negedge clk);
    rst = 1'b0;
    model_cnt = '0;
    #1;
    chk("midop_after_mem_req", int'(mem_req), 1);
    chk("midop_after_mem_we", int'(mem_we), 0);
    chk("midop_after_instret", int'(instret), 0);

    run_instr(32'h00500093, C_OPIMM, 0, 0, 1'b0);
    run_instr(32'h0020A023, C_STORE, 0, 2, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
